// File: rtl/onewire_pkg.sv
// Shared types and slot timing for the 1-Wire bit PHY.
// Times are in microseconds and are scaled by the clock prescaler in the PHY.
package onewire_pkg;

  typedef enum logic [1:0] {
    OP_RESET  = 2'd0,
    OP_WRITE0 = 2'd1,
    OP_WRITE1 = 2'd2,
    OP_READ   = 2'd3
  } onewire_op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOW,
    ST_RELEASE,
    ST_DONE
  } onewire_state_t;

  localparam int US_W = 10;

  localparam logic [US_W-1:0] T_RST_LOW    = 10'd480;
  localparam logic [US_W-1:0] T_RST_SAMPLE = 10'd550;
  localparam logic [US_W-1:0] T_RST_SLOT   = 10'd960;
  localparam logic [US_W-1:0] T_W0_LOW     = 10'd60;
  localparam logic [US_W-1:0] T_W1_LOW     = 10'd6;
  localparam logic [US_W-1:0] T_RD_LOW     = 10'd6;
  localparam logic [US_W-1:0] T_RD_SAMPLE  = 10'd15;
  localparam logic [US_W-1:0] T_SLOT       = 10'd70;

  function automatic logic [US_W-1:0] t_low(input onewire_op_t op);
    case (op)
      OP_RESET:  return T_RST_LOW;
      OP_WRITE0: return T_W0_LOW;
      OP_WRITE1: return T_W1_LOW;
      default:   return T_RD_LOW;
    endcase
  endfunction

  // Write slots never sample; their sample point is parked at the slot end.
  function automatic logic [US_W-1:0] t_sample(input onewire_op_t op);
    case (op)
      OP_RESET: return T_RST_SAMPLE;
      OP_READ:  return T_RD_SAMPLE;
      default:  return T_SLOT;
    endcase
  endfunction

  function automatic logic [US_W-1:0] t_slot(input onewire_op_t op);
    return (op == OP_RESET) ? T_RST_SLOT : T_SLOT;
  endfunction

endpackage

// File: rtl/onewire_if.sv
// Command/response handshake between the sensor command FSM (master) and the bit PHY (slave).
interface onewire_if;
  import onewire_pkg::*;

  logic        cmd_valid;
  onewire_op_t cmd_op;
  logic        cmd_ready;
  logic        rsp_valid;
  logic        rsp_bit;

  modport master (
    output cmd_valid, cmd_op,
    input  cmd_ready, rsp_valid, rsp_bit
  );

  modport slave (
    input  cmd_valid, cmd_op,
    output cmd_ready, rsp_valid, rsp_bit
  );

endinterface

// File: rtl/onewire_tick_gen.sv
// Microsecond prescaler: tick_o is high for one cycle every DIV cycles.
// A synchronous clear restarts the count so the first tick lands DIV cycles later.
module onewire_tick_gen #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clr_i,
  output logic tick_o
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == CW'(DIV - 1));

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr_i || tick_o) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/onewire_bit_phy.sv
// 1-Wire master bit PHY: one command = one reset/write/read slot on open-drain DQ.
// Optional ONEWIRE_GLITCH_FILTER_EN: majority-of-3 sampling of the synchronized DQ.
module onewire_bit_phy
  import onewire_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 10_000_000
) (
  input  logic        clk,
  input  logic        n_rst,
  onewire_if.slave    bus,
  output logic        dq_oe,
  input  logic        dq_in
);

  localparam int DIV = CLK_FREQ_HZ / 1_000_000;

  onewire_state_t   state_q;
  onewire_op_t      op_q;
  logic             dq_oe_q;
  logic             ready_q;
  logic             rsp_valid_q;
  logic             rsp_bit_q;
  logic             sample_q;
  logic             sync1_q, sync2_q;
  logic [US_W-1:0]  us_cnt_q, us_cnt_d;
  logic             tick;
  logic             accept;
  logic             sample_val;
  logic             hit_low, hit_sample, hit_slot;

  assign accept        = bus.cmd_valid && ready_q;
  assign bus.cmd_ready = ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_bit   = rsp_bit_q;
  assign dq_oe         = dq_oe_q;

  onewire_tick_gen #(.DIV(DIV)) u_tick (
    .clk    (clk),
    .n_rst  (n_rst),
    .clr_i  (accept),
    .tick_o (tick)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= dq_in;
      sync2_q <= sync1_q;
    end
  end

`ifdef ONEWIRE_GLITCH_FILTER_EN
  logic [1:0] hist_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) hist_q <= 2'b11;
    else        hist_q <= {hist_q[0], sync2_q};
  end

  assign sample_val = (sync2_q & hist_q[0]) | (sync2_q & hist_q[1]) | (hist_q[0] & hist_q[1]);
`else
  assign sample_val = sync2_q;
`endif

  always_comb begin
    us_cnt_d = us_cnt_q;
    if (accept)                        us_cnt_d = '0;
    else if (tick && (us_cnt_q != '1)) us_cnt_d = us_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) us_cnt_q <= '0;
    else        us_cnt_q <= us_cnt_d;
  end

  // Events fire on the tick that moves us_cnt onto the target, so every edge of
  // the waveform lands exactly T*DIV cycles after accept.
  assign hit_low    = tick && (us_cnt_q == t_low(op_q)    - 1'b1);
  assign hit_sample = tick && (us_cnt_q == t_sample(op_q) - 1'b1);
  assign hit_slot   = tick && (us_cnt_q == t_slot(op_q)   - 1'b1);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_RESET;
      dq_oe_q     <= 1'b0;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_bit_q   <= 1'b0;
      sample_q    <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            op_q    <= bus.cmd_op;
            dq_oe_q <= 1'b1;
            ready_q <= 1'b0;
            state_q <= ST_LOW;
          end
        end
        ST_LOW: begin
          if (hit_low) begin
            dq_oe_q <= 1'b0;
            state_q <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (hit_sample) sample_q <= sample_val;
          if (hit_slot) begin
            rsp_valid_q <= 1'b1;
            state_q     <= ST_DONE;
            case (op_q)
              OP_RESET: rsp_bit_q <= ~sample_q;
              OP_READ:  rsp_bit_q <= sample_q;
              default:  rsp_bit_q <= 1'b0;
            endcase
          end
        end
        default: begin
          rsp_valid_q <= 1'b0;
          ready_q     <= 1'b1;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_onewire_bit_phy.sv
// Randomized slot stimulus against a line-level model: expected bits come from the
// DQ level at the nominal sample instant, expected timing from slot arithmetic.
`timescale 1ns/1ps
module tb_onewire_bit_phy;
  import onewire_pkg::*;

  localparam int DIV = 10;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic dq_oe;
  logic dq_in;
  logic dev_pull;

  int total = 0;
  int bad = 0;
  int since_acc = 100000;
  int win_lo_us = 0;
  int win_hi_us = 0;
  int glitch_at = -1;
  int n_resets = 0;

  onewire_if bus ();

  onewire_bit_phy #(.CLK_FREQ_HZ(10_000_000)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus),
    .dq_oe (dq_oe),
    .dq_in (dq_in)
  );

  always #50 clk = ~clk;

  always @(posedge clk) begin
    if (bus.cmd_valid && bus.cmd_ready) since_acc <= 0;
    else                                since_acc <= since_acc + 1;
  end

  // Device model: pulls DQ low over a microsecond window after accept, plus an optional single-cycle glitch.
  always_comb begin
    dev_pull = 1'b0;
    if (since_acc >= win_lo_us * DIV && since_acc < win_hi_us * DIV) dev_pull = 1'b1;
    if (since_acc == glitch_at) dev_pull = 1'b1;
  end

  assign dq_in = !(dq_oe || dev_pull);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int exp_low_us(input int op);
    case (op)
      0: return 480;
      1: return 60;
      default: return 6;
    endcase
  endfunction

  function automatic int exp_slot_us(input int op);
    return (op == 0) ? 960 : 70;
  endfunction

  function automatic int exp_sample_us(input int op);
    return (op == 0) ? 550 : 15;
  endfunction

  // Expected response from the line level at the nominal sample instant.
  function automatic int model_bit(input int op);
    bit line_low;
    line_low = (win_lo_us <= exp_sample_us(op)) && (win_hi_us > exp_sample_us(op));
    case (op)
      0: return line_low ? 1 : 0;
      3: return line_low ? 0 : 1;
      default: return 0;
    endcase
  endfunction

  function automatic int near(input int got, input int exp);
    return (got >= exp - 1 && got <= exp + 1) ? exp : got;
  endfunction

  // Called at a negedge; returns at the negedge on which rsp_valid is seen.
  task automatic run_slot(input int op, input int exp_bit, input bit b2b, input string tag);
    int waits;
    int k;
    int low;
    bit got;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = onewire_op_t'(op);
    waits = 0;
    while (!bus.cmd_ready && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    if (waits >= 20) begin
      check({tag, "_accept_timeout"}, 0, 1);
      bus.cmd_valid = 1'b0;
      return;
    end
    if (b2b) check({tag, "_b2b_wait"}, waits, 1);
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    k = 0;
    low = 0;
    got = 1'b0;
    while (k < 12000) begin
      @(negedge clk);
      k++;
      if (dq_oe) low++;
      if (k == 1) check({tag, "_ready_busy"}, bus.cmd_ready, 0);
      if (bus.rsp_valid) begin
        got = 1'b1;
        break;
      end
    end
    check({tag, "_rsp_seen"}, got, 1);
    check({tag, "_low_cycles"}, near(low, exp_low_us(op) * DIV), exp_low_us(op) * DIV);
    check({tag, "_rsp_latency"}, near(k, exp_slot_us(op) * DIV + 1), exp_slot_us(op) * DIV + 1);
    check({tag, "_rsp_bit"}, bus.rsp_bit, exp_bit);
  endtask

  task automatic set_dev(input int lo, input int hi, input int gl);
    win_lo_us = lo;
    win_hi_us = hi;
    glitch_at = gl;
  endtask

  initial begin
    int op;
    int lo;
    int hi;
    int rsp_cnt;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = OP_RESET;

    repeat (3) @(negedge clk);
    check("rst_dq_oe", dq_oe, 0);
    check("rst_cmd_ready", bus.cmd_ready, 1);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_bit", bus.rsp_bit, 0);
    n_rst = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_dq_oe", dq_oe, 0);
    check("idle_cmd_ready", bus.cmd_ready, 1);

    set_dev(500, 600, -1);
    run_slot(0, model_bit(0), 1'b0, "reset_presence");
    @(negedge clk);
    set_dev(0, 0, -1);
    run_slot(0, model_bit(0), 1'b0, "reset_absent");

    repeat (5) @(negedge clk);
    run_slot(2, 0, 1'b0, "write1");
    run_slot(1, 0, 1'b1, "write0_b2b");

    set_dev(0, 20, -1);
    run_slot(3, model_bit(3), 1'b1, "read_held");
    set_dev(0, 0, -1);
    run_slot(3, model_bit(3), 1'b1, "read_free");

    // Reset asserted 200 us into a RESET slot.
    @(negedge clk);
    set_dev(500, 600, -1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_RESET;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    repeat (2000) @(posedge clk);
    #20 n_rst = 1'b0;
    #1 check("abort_dq_oe", dq_oe, 0);
    check("abort_ready", bus.cmd_ready, 1);
    rsp_cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.rsp_valid) rsp_cnt++;
    end
    n_rst = 1'b1;
    set_dev(0, 0, -1);
    repeat (8000) begin
      @(negedge clk);
      if (bus.rsp_valid) rsp_cnt++;
    end
    check("abort_no_rsp", rsp_cnt, 0);
    run_slot(3, 1, 1'b0, "read_after_abort");

    // One-cycle low glitch landing exactly at the READ sample point.
    set_dev(0, 0, 15 * DIV - 3);
`ifdef ONEWIRE_GLITCH_FILTER_EN
    run_slot(3, 1, 1'b0, "read_glitch");
`else
    run_slot(3, 0, 1'b0, "read_glitch");
`endif

    n_resets = 0;
    for (int i = 0; i < 8; i++) begin
      op = $urandom_range(0, 3);
      if (op == 0) begin
        if (n_resets >= 2) op = 3;
        else n_resets++;
      end
      if (op == 0) begin
        lo = $urandom_range(490, 540);
        hi = lo + $urandom_range(5, 80);
        if (hi >= 547 && hi <= 553) hi += 10;
      end else begin
        lo = ($urandom_range(0, 1) != 0) ? 0 : $urandom_range(17, 30);
        hi = lo + $urandom_range(1, 40);
        if (hi >= 13 && hi <= 17) hi += 6;
      end
      set_dev(lo, hi, -1);
      if ($urandom_range(0, 1) != 0) repeat ($urandom_range(1, 20)) @(negedge clk);
      run_slot(op, model_bit(op), 1'b0, $sformatf("rand%0d_op%0d", i, op));
      @(negedge clk);
      check($sformatf("rand%0d_rsp_hold", i), bus.rsp_bit, model_bit(op));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
